router_out_arb: RTL

- Packet-granular round-robin read scheduler: drains the three router output FIFOs onto one shared 8-bit egress channel.
- Owns every FIFO read strobe and always transfers a whole packet (header, payload, parity) before re-arbitrating.
- Sits between the FIFO bank and the single off-chip egress port. Downstream backpressure uses a valid/ready handshake.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_rr_pick.sv | 30 +++
 rtl/router_out_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router egress arbiter: FSM encoding,
// header field positions and the mod-3 pointer increment.
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  localparam int         NUM_PORTS  = 3;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  function automatic logic [1:0] inc_mod3(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Rotating-priority picker: first set request bit at or above ptr, wrapping mod 3.
module router_rr_pick
  import router_pkg::*;
(
  input  logic [2:0] request,
  input  logic [1:0] ptr,
  output logic       hit,
  output logic [1:0] idx
);

  logic [1:0] c0, c1, c2;

  // An out-of-range pointer behaves as 0 so the search never skips a port.
  assign c0 = (ptr == 2'd3) ? 2'd0 : ptr;
  assign c1 = inc_mod3(c0);
  assign c2 = inc_mod3(c1);

  always_comb begin
    hit = 1'b1;
    idx = c0;
    if (request[c0])      idx = c0;
    else if (request[c1]) idx = c1;
    else if (request[c2]) idx = c2;
    else begin
      hit = 1'b0;
      idx = 2'd0;
    end
  end

endmodule

// File: rtl/router_out_arb.sv
// Packet-granular round-robin drain of three FIFOs onto one valid/ready egress.
// Optional starvation watchdog: define ROUTER_OUT_ARB_WATCHDOG_EN.
module router_out_arb #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3,
  parameter int TIMEOUT   = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [DATA_W-1:0]    fifo_dout0,
  input  logic [DATA_W-1:0]    fifo_dout1,
  input  logic [DATA_W-1:0]    fifo_dout2,
  output logic [NUM_PORTS-1:0] read_enb,
  input  logic                 out_rdy,
  output logic [DATA_W-1:0]    data_out,
  output logic                 vld_out,
  output logic                 sop,
  output logic                 eop,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] soft_rst,
  output logic                 err
);
  import router_pkg::*;

  if (NUM_PORTS != 3 || DATA_W != 8 || TIMEOUT < 1 || TIMEOUT > 31) begin : g_param_chk
    $error("router_out_arb: unsupported parameter set");
  end

  state_e                 state_q;
  logic [1:0]             rr_ptr_q, grant_q;
  logic [6:0]             rem_q;
  logic [DATA_W-1:0]      data_q;
  logic                   vld_q, sop_q, eop_q, busy_q, err_q;
  logic [NUM_PORTS-1:0]   soft_rst_q;

  logic [DATA_W-1:0]      head;
  logic                   head_empty, slot_free, pop;
  logic                   pick_hit;
  logic [1:0]             pick_idx;

  always_comb begin
    head       = '0;
    head_empty = 1'b1;
    case (grant_q)
      2'd0: begin head = fifo_dout0; head_empty = empty[0]; end
      2'd1: begin head = fifo_dout1; head_empty = empty[1]; end
      2'd2: begin head = fifo_dout2; head_empty = empty[2]; end
      default: ;
    endcase
  end

  assign slot_free = !vld_q || out_rdy;
  assign pop       = (state_q == ST_HDR || state_q == ST_XFER) && !head_empty && slot_free;

  always_comb begin
    read_enb = '0;
    if (pop) read_enb[grant_q] = 1'b1;
  end

  router_rr_pick u_pick (
    .request (~empty),
    .ptr     (rr_ptr_q),
    .hit     (pick_hit),
    .idx     (pick_idx)
  );

`ifdef ROUTER_OUT_ARB_WATCHDOG_EN
  localparam logic [4:0] WD_LAST = 5'(TIMEOUT - 1);
  logic [4:0] wd_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      grant_q    <= GRANT_NONE;
      rem_q      <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      busy_q     <= 1'b0;
      soft_rst_q <= '0;
      err_q      <= 1'b0;
`ifdef ROUTER_OUT_ARB_WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      soft_rst_q <= '0;
      err_q      <= 1'b0;

      // Output register only moves when the downstream slot is free.
      if (slot_free) begin
        vld_q <= pop;
        if (pop) data_q <= head;
        else begin
          sop_q <= 1'b0;
          eop_q <= 1'b0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (pick_hit) begin
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (pop) begin
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            rem_q   <= {1'b0, head[LEN_MSB:LEN_LSB]} + 7'd1;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (pop) begin
            sop_q <= 1'b0;
            rem_q <= rem_q - 7'd1;
            if (rem_q == 7'd1) begin
              eop_q    <= 1'b1;
              rr_ptr_q <= inc_mod3(grant_q);
              grant_q  <= GRANT_NONE;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              eop_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

`ifdef ROUTER_OUT_ARB_WATCHDOG_EN
      // Only an empty owned FIFO counts as starvation; downstream stalls do not.
      if (state_q == ST_IDLE || pop) begin
        wd_q <= '0;
      end else if (head_empty) begin
        if (wd_q == WD_LAST) begin
          wd_q                <= '0;
          soft_rst_q[grant_q] <= 1'b1;
          err_q               <= 1'b1;
          rr_ptr_q            <= inc_mod3(grant_q);
          grant_q             <= GRANT_NONE;
          busy_q              <= 1'b0;
          state_q             <= ST_IDLE;
        end else begin
          wd_q <= wd_q + 5'd1;
        end
      end
`endif
    end
  end

  assign data_out = data_q;
  assign vld_out  = vld_q;
  assign sop      = sop_q;
  assign eop      = eop_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign soft_rst = soft_rst_q;
  assign err      = err_q;

endmodule
